// File: rtl/vram_write_arbiter_pkg.sv
// Shared definitions for the video-RAM write arbiter.
// Holds the fill FSM state encoding, the write-source priority order and coordinate helpers.
package vram_write_arbiter_pkg;

  localparam int unsigned AddrWidth  = 16;
  localparam int unsigned CoordWidth = 8;
  localparam int unsigned ColorWidth = 3;

  typedef enum logic [1:0] {
    FillIdle = 2'd0,
    FillRun  = 2'd1,
    FillDone = 2'd2
  } fillState_e;

  // Write sources; a lower encoding outranks a higher one (CPU > cursor > fill).
  typedef enum logic [1:0] {
    SrcCpu    = 2'd0,
    SrcCursor = 2'd1,
    SrcFill   = 2'd2,
    SrcNone   = 2'd3
  } writeSrc_e;

  function automatic writeSrc_e pickSource(input logic cpuReq, input logic cursorReq,
                                           input logic fillReq);
    if (cpuReq) begin
      return SrcCpu;
    end else if (cursorReq) begin
      return SrcCursor;
    end else if (fillReq) begin
      return SrcFill;
    end
    return SrcNone;
  endfunction

  function automatic logic [CoordWidth-1:0] minCoord(input logic [CoordWidth-1:0] a,
                                                     input logic [CoordWidth-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [CoordWidth-1:0] maxCoord(input logic [CoordWidth-1:0] a,
                                                     input logic [CoordWidth-1:0] b);
    return (a < b) ? b : a;
  endfunction

endpackage

// File: rtl/vram_fill_engine.sv
// Rectangle fill engine: walks a latched rectangle row by row, one pixel per grant.
// Instantiated by vram_write_arbiter only when VRAM_ARB_FILL_EN is defined.
module vram_fill_engine
  import vram_write_arbiter_pkg::*;
(
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [CoordWidth-1:0] iX0,
  input  logic [CoordWidth-1:0] iY0,
  input  logic [CoordWidth-1:0] iX1,
  input  logic [CoordWidth-1:0] iY1,
  input  logic [ColorWidth-1:0] iColor,
  input  logic                  iGnt,
  output logic                  oReq,
  output logic [AddrWidth-1:0]  oAddr,
  output logic [ColorWidth-1:0] oData,
  output logic                  oBusy,
  output logic                  oDone
);

  fillState_e            state;
  logic [CoordWidth-1:0] xPos;
  logic [CoordWidth-1:0] yPos;
  logic [CoordWidth-1:0] xMin;
  logic [CoordWidth-1:0] xMax;
  logic [CoordWidth-1:0] yMax;
  logic [ColorWidth-1:0] color;

  // Fill FSM with its counters, latched bounds and registered done pulse.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= FillIdle;
      xPos  <= '0;
      yPos  <= '0;
      xMin  <= '0;
      xMax  <= '0;
      yMax  <= '0;
      color <= '0;
      oDone <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        FillIdle: begin
          if (iStart) begin
            xMin  <= minCoord(iX0, iX1);
            xMax  <= maxCoord(iX0, iX1);
            yMax  <= maxCoord(iY0, iY1);
            xPos  <= minCoord(iX0, iX1);
            yPos  <= minCoord(iY0, iY1);
            color <= iColor;
            state <= FillRun;
          end
        end
        FillRun: begin
          // Compare before incrementing so a 0..255 span never wraps.
          if (iGnt) begin
            if (xPos < xMax) begin
              xPos <= xPos + 8'd1;
            end else begin
              xPos <= xMin;
              if (yPos < yMax) begin
                yPos <= yPos + 8'd1;
              end else begin
                state <= FillDone;
                oDone <= 1'b1;
              end
            end
          end
        end
        FillDone: state <= FillIdle;
        default:  state <= FillIdle;
      endcase
    end
  end

  assign oReq  = (state == FillRun);
  assign oBusy = (state != FillIdle);
  assign oAddr = {xPos, yPos};
  assign oData = color;

endmodule

// File: rtl/vram_write_arbiter.sv
// Video-RAM write arbiter: CPU > PS/2 cursor > rectangle fill, one registered write port.
// The fill engine is compiled only when VRAM_ARB_FILL_EN is defined; otherwise the fill
// ports are ignored and oFillBusy/oFillDone stay low.
module vram_write_arbiter
  import vram_write_arbiter_pkg::*;
(
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iCpuReq,
  input  logic [AddrWidth-1:0]  iCpuAddr,
  input  logic [ColorWidth-1:0] iCpuColor,
  input  logic                  iCursorReq,
  input  logic [AddrWidth-1:0]  iCursorAddr,
  input  logic [ColorWidth-1:0] iCursorColor,
  output logic                  oCursorGnt,
  input  logic                  iFillStart,
  input  logic [CoordWidth-1:0] iFillX0,
  input  logic [CoordWidth-1:0] iFillY0,
  input  logic [CoordWidth-1:0] iFillX1,
  input  logic [CoordWidth-1:0] iFillY1,
  input  logic [ColorWidth-1:0] iFillColor,
  output logic                  oFillBusy,
  output logic                  oFillDone,
  output logic                  oWriteEnable,
  output logic [AddrWidth-1:0]  oWriteAddr,
  output logic [ColorWidth-1:0] oWriteData
);

  logic                  fillReq;
  logic [AddrWidth-1:0]  fillAddr;
  logic [ColorWidth-1:0] fillData;
  writeSrc_e             winner;
  logic [AddrWidth-1:0]  winAddr;
  logic [ColorWidth-1:0] winData;

`ifdef VRAM_ARB_FILL_EN
  logic fillGnt;
  assign fillGnt = (winner == SrcFill);

  vram_fill_engine uFillEngine (
    .Clock  (Clock),
    .Reset  (Reset),
    .iStart (iFillStart),
    .iX0    (iFillX0),
    .iY0    (iFillY0),
    .iX1    (iFillX1),
    .iY1    (iFillY1),
    .iColor (iFillColor),
    .iGnt   (fillGnt),
    .oReq   (fillReq),
    .oAddr  (fillAddr),
    .oData  (fillData),
    .oBusy  (oFillBusy),
    .oDone  (oFillDone)
  );
`else
  logic unusedFillInputs;
  assign unusedFillInputs = ^{iFillStart, iFillX0, iFillY0, iFillX1, iFillY1, iFillColor};
  assign fillReq   = 1'b0;
  assign fillAddr  = '0;
  assign fillData  = '0;
  assign oFillBusy = 1'b0;
  assign oFillDone = 1'b0;
`endif

  // Cursor is granted whenever the CPU is not writing, including during reset.
  assign oCursorGnt = iCursorReq & ~iCpuReq;

  // Fixed-priority pick and address/data mux of the winning source.
  always_comb begin
    winner  = pickSource(iCpuReq, iCursorReq, fillReq);
    winAddr = iCpuAddr;
    winData = iCpuColor;
    case (winner)
      SrcCursor: begin
        winAddr = iCursorAddr;
        winData = iCursorColor;
      end
      SrcFill: begin
        winAddr = fillAddr;
        winData = fillData;
      end
      default: begin
        winAddr = iCpuAddr;
        winData = iCpuColor;
      end
    endcase
  end

  // Registered write port; address/data hold their last value on idle cycles.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oWriteEnable <= 1'b0;
      oWriteAddr   <= '0;
      oWriteData   <= '0;
    end else begin
      oWriteEnable <= (winner != SrcNone);
      if (winner != SrcNone) begin
        oWriteAddr <= winAddr;
        oWriteData <= winData;
      end
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter: directed cases plus randomized traffic
// checked against a pixel-list reference model. Fill cases run when VRAM_ARB_FILL_EN is set.
module tb_vram_write_arbiter;

`ifdef VRAM_ARB_FILL_EN
  localparam bit FillEn = 1'b1;
`else
  localparam bit FillEn = 1'b0;
`endif

  localparam int PhIdle = 0;
  localparam int PhRun  = 1;
  localparam int PhDone = 2;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iCpuReq;
  logic [15:0] iCpuAddr;
  logic [2:0]  iCpuColor;
  logic        iCursorReq;
  logic [15:0] iCursorAddr;
  logic [2:0]  iCursorColor;
  logic        oCursorGnt;
  logic        iFillStart;
  logic [7:0]  iFillX0, iFillY0, iFillX1, iFillY1;
  logic [2:0]  iFillColor;
  logic        oFillBusy, oFillDone;
  logic        oWriteEnable;
  logic [15:0] oWriteAddr;
  logic [2:0]  oWriteData;

  int testCount = 0;
  int failCount = 0;

  // Reference model: pending fill pixels as a list, plus the last written port value.
  int          phase;
  logic [15:0] fillQ[$];
  logic [15:0] obsFill[$];
  logic [2:0]  mColor;
  logic [15:0] mAddr;
  logic [2:0]  mData;
  bit          curGranted;
  logic        lastGnt;
  int fillSeen, cpuSeen, cpuIssued, busyCycles, doneCount;
  logic [15:0] lastFillAddr;

  always #5 Clock = ~Clock;

  vram_write_arbiter dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iCpuReq      (iCpuReq),
    .iCpuAddr     (iCpuAddr),
    .iCpuColor    (iCpuColor),
    .iCursorReq   (iCursorReq),
    .iCursorAddr  (iCursorAddr),
    .iCursorColor (iCursorColor),
    .oCursorGnt   (oCursorGnt),
    .iFillStart   (iFillStart),
    .iFillX0      (iFillX0),
    .iFillY0      (iFillY0),
    .iFillX1      (iFillX1),
    .iFillY1      (iFillY1),
    .iFillColor   (iFillColor),
    .oFillBusy    (oFillBusy),
    .oFillDone    (oFillDone),
    .oWriteEnable (oWriteEnable),
    .oWriteAddr   (oWriteAddr),
    .oWriteData   (oWriteData)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    iCpuReq      = 1'b0;
    iCpuAddr     = '0;
    iCpuColor    = '0;
    iCursorReq   = 1'b0;
    iCursorAddr  = '0;
    iCursorColor = '0;
    iFillStart   = 1'b0;
    iFillX0      = '0;
    iFillY0      = '0;
    iFillX1      = '0;
    iFillY1      = '0;
    iFillColor   = '0;
  endtask

  // Expand the requested rectangle into its pixel list, row by row.
  task automatic latchFill();
    int xa, xb, ya, yb;
    xa = (iFillX0 < iFillX1) ? int'(iFillX0) : int'(iFillX1);
    xb = (iFillX0 < iFillX1) ? int'(iFillX1) : int'(iFillX0);
    ya = (iFillY0 < iFillY1) ? int'(iFillY0) : int'(iFillY1);
    yb = (iFillY0 < iFillY1) ? int'(iFillY1) : int'(iFillY0);
    fillQ.delete();
    for (int yy = ya; yy <= yb; yy++) begin
      for (int xx = xa; xx <= xb; xx++) begin
        fillQ.push_back({xx[7:0], yy[7:0]});
      end
    end
    mColor = iFillColor;
  endtask

  // One clock: inputs are already set; predict the write, then compare after the edge.
  task automatic step();
    bit cpuWin, curWin, fillWin, eWe;
    @(negedge Clock);
    lastGnt = oCursorGnt;
    cpuWin  = iCpuReq;
    curWin  = !iCpuReq && iCursorReq;
    fillWin = !iCpuReq && !iCursorReq && (phase == PhRun);
    check("cursor_gnt", oCursorGnt, curWin);
    eWe = cpuWin || curWin || fillWin;
    if (cpuWin) begin
      mAddr = iCpuAddr;
      mData = iCpuColor;
      cpuIssued++;
    end else if (curWin) begin
      mAddr = iCursorAddr;
      mData = iCursorColor;
    end else if (fillWin) begin
      mAddr = fillQ.pop_front();
      mData = mColor;
    end
    curGranted = curWin;
    case (phase)
      PhIdle: begin
        if (FillEn && iFillStart) begin
          latchFill();
          phase = PhRun;
        end
      end
      PhRun:   if (fillWin && fillQ.size() == 0) phase = PhDone;
      default: phase = PhIdle;
    endcase
    @(posedge Clock);
    #1;
    check("write_enable", oWriteEnable, eWe);
    check("write_addr", oWriteAddr, mAddr);
    check("write_data", oWriteData, mData);
    check("fill_busy", oFillBusy, phase != PhIdle);
    check("fill_done", oFillDone, phase == PhDone);
    if (oWriteEnable) begin
      if (cpuWin) begin
        cpuSeen++;
      end else if (!iCursorReq) begin
        fillSeen++;
        lastFillAddr = oWriteAddr;
        obsFill.push_back(oWriteAddr);
      end
    end
    if (oFillBusy) busyCycles++;
    if (oFillDone) doneCount++;
  endtask

  // Asynchronous reset a little after an edge, with a cursor request pending.
  task automatic resetMid();
    #2;
    idle();
    iCursorReq  = 1'b1;
    iCursorAddr = 16'h7777;
    Reset       = 1'b1;
    #1;
    check("rst_we", oWriteEnable, 1'b0);
    check("rst_addr", oWriteAddr, 16'h0000);
    check("rst_data", oWriteData, 3'b000);
    check("rst_busy", oFillBusy, 1'b0);
    check("rst_done", oFillDone, 1'b0);
    check("rst_cursor_gnt", oCursorGnt, 1'b1);
    mAddr = '0;
    mData = '0;
    phase = PhIdle;
    fillQ.delete();
    @(posedge Clock);
    #1;
    check("rst_no_write", oWriteEnable, 1'b0);
    Reset      = 1'b0;
    iCursorReq = 1'b0;
    curGranted = 1'b0;
  endtask

  initial begin
    logic [7:0] a, b;
    idle();
    phase = PhIdle;
    mAddr = '0;
    mData = '0;
    mColor = '0;
    curGranted = 1'b0;
    fillSeen = 0; cpuSeen = 0; cpuIssued = 0; busyCycles = 0; doneCount = 0;
    lastFillAddr = '0;
    Reset = 1'b1;
    #12;
    check("reset_we", oWriteEnable, 1'b0);
    check("reset_addr", oWriteAddr, 16'h0000);
    check("reset_data", oWriteData, 3'b000);
    check("reset_busy", oFillBusy, 1'b0);
    check("reset_done", oFillDone, 1'b0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;

    // Single CPU write, then an idle cycle that must hold address/data.
    iCpuReq = 1'b1; iCpuAddr = 16'h1020; iCpuColor = 3'b100;
    step();
    check("cpu_we", oWriteEnable, 1'b1);
    check("cpu_addr", oWriteAddr, 16'h1020);
    check("cpu_data", oWriteData, 3'b100);
    idle();
    step();
    check("hold_we", oWriteEnable, 1'b0);
    check("hold_addr", oWriteAddr, 16'h1020);

    // CPU and cursor together for two cycles, then the CPU drops.
    iCpuReq = 1'b1; iCpuAddr = 16'h0101; iCpuColor = 3'b001;
    iCursorReq = 1'b1; iCursorAddr = 16'h2233; iCursorColor = 3'b011;
    step();
    check("contend_gnt0", lastGnt, 1'b0);
    step();
    check("contend_gnt1", lastGnt, 1'b0);
    iCpuReq = 1'b0;
    step();
    check("contend_gnt2", lastGnt, 1'b1);
    check("cursor_addr", oWriteAddr, 16'h2233);
    check("cursor_data", oWriteData, 3'b011);
    idle();
    step();
    resetMid();
    step();

`ifdef VRAM_ARB_FILL_EN
    begin
      logic [15:0] expOrder[6];
      expOrder = '{16'h0307, 16'h0407, 16'h0507, 16'h0308, 16'h0408, 16'h0508};
      obsFill.delete();
      busyCycles = 0; doneCount = 0;
      iFillStart = 1'b1; iFillX0 = 8'd5; iFillX1 = 8'd3; iFillY0 = 8'd7; iFillY1 = 8'd8;
      iFillColor = 3'b010;
      step();
      for (int i = 0; i < 10; i++) begin
        // A start mid-fill must be ignored.
        iFillStart = (i == 2);
        iFillX0 = 8'd100; iFillX1 = 8'd120; iFillColor = 3'b111;
        step();
      end
      idle();
      check("rect_count", obsFill.size(), 6);
      for (int i = 0; i < 6 && i < obsFill.size(); i++) check("rect_order", obsFill[i],
                                                               expOrder[i]);
      check("rect_busy_cycles", busyCycles, 7);
      check("rect_done_pulses", doneCount, 1);
    end

    // Fill started together with a CPU write, reset after 10 fill writes.
    fillSeen = 0;
    iFillStart = 1'b1; iFillX0 = 8'd0; iFillX1 = 8'd20; iFillY0 = 8'd20; iFillY1 = 8'd0;
    iFillColor = 3'b110; iCpuReq = 1'b1; iCpuAddr = 16'hABCD; iCpuColor = 3'b101;
    step();
    check("start_with_cpu_addr", oWriteAddr, 16'hABCD);
    idle();
    for (int c = 0; c < 100 && fillSeen < 10; c++) step();
    check("mid_fill_writes", fillSeen, 10);
    resetMid();
    busyCycles = 0; doneCount = 0;
    for (int c = 0; c < 30; c++) step();
    check("after_rst_busy", busyCycles, 0);
    check("after_rst_done", doneCount, 0);

    // Full-screen fill with a CPU strobe every fourth cycle.
    fillSeen = 0; cpuSeen = 0; cpuIssued = 0; doneCount = 0;
    iFillStart = 1'b1; iFillX0 = 8'd255; iFillX1 = 8'd0; iFillY0 = 8'd0; iFillY1 = 8'd255;
    iFillColor = 3'b001;
    step();
    iFillStart = 1'b0;
    for (int c = 0; c < 90000 && oFillBusy; c++) begin
      iCpuReq   = (c % 4 == 3);
      iCpuAddr  = 16'($urandom);
      iCpuColor = 3'($urandom);
      step();
    end
    idle();
    check("full_fill_finished", oFillBusy, 1'b0);
    check("full_fill_writes", fillSeen, 65536);
    check("full_fill_cpu_kept", cpuSeen, cpuIssued);
    check("full_fill_last_addr", lastFillAddr, 16'hFFFF);
    check("full_fill_done", doneCount, 1);
    step();
`else
    // Fill build disabled: a start pulse must produce nothing.
    fillSeen = 0; busyCycles = 0; doneCount = 0;
    iFillStart = 1'b1; iFillX0 = 8'd1; iFillX1 = 8'd4; iFillY0 = 8'd2; iFillY1 = 8'd3;
    step();
    idle();
    for (int c = 0; c < 8; c++) step();
    check("nofill_writes", fillSeen, 0);
    check("nofill_busy", busyCycles, 0);
    check("nofill_done", doneCount, 0);
`endif

    // Randomized mix of CPU strobes, cursor handshakes and small fills.
    idle();
    curGranted = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      iCpuReq   = ($urandom_range(0, 2) == 0);
      iCpuAddr  = 16'($urandom);
      iCpuColor = 3'($urandom);
      if (curGranted || !iCursorReq) begin
        iCursorReq   = ($urandom_range(0, 1) == 1);
        iCursorAddr  = 16'($urandom);
        iCursorColor = 3'($urandom);
      end
      iFillStart = ($urandom_range(0, 29) == 0);
      a = 8'($urandom_range(0, 250));
      b = a + 8'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        iFillX0 = a; iFillX1 = b;
      end else begin
        iFillX0 = b; iFillX1 = a;
      end
      a = 8'($urandom_range(0, 250));
      b = a + 8'($urandom_range(0, 4));
      iFillY0 = b; iFillY1 = a;
      iFillColor = 3'($urandom);
      step();
    end
    idle();
    for (int c = 0; c < 200 && oFillBusy; c++) step();
    check("random_end_idle", oFillBusy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
